mant_div: RTL and testbench



---
 rtl/divsqrt_pkg.sv | 22 ++
 rtl/mant_div_norm.sv | 34 +++
 rtl/mant_div.sv | 134 +++++++++++++
 tb/tb_mant_div.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/divsqrt_pkg.sv
// Shared definitions for the FP divide/sqrt significand datapath.
// Holds the fraction width, the divider quotient width, the iteration counter width,
// the divider FSM state type and the op encoding shared with exponent_op.
package divsqrt_pkg;

  // Fraction width; the significand is 1.f, NF+1 bits.
  localparam int unsigned NF   = 23;
  // Quotient bits: 1 integer + NF fraction + G + R + 1 spare for normalization.
  localparam int unsigned QB   = NF + 4;
  localparam int unsigned CntW = $clog2(QB + 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } div_state_e;

  // Op encoding, matches exponent_op.
  localparam logic [1:0] OpDiv  = 2'b00;
  localparam logic [1:0] OpSqrt = 2'b01;

endpackage

// File: rtl/mant_div_norm.sv
// Quotient normalization for the significand divider (purely combinational).
// Ports:
//   q_i         raw quotient, q_i[QB-1] is the integer bit
//   rem_i       final partial remainder
//   q_m_o       normalized fraction {frac[NF-1:0], G, R}
//   sticky_o    OR of discarded quotient bits and nonzero remainder
//   decrement_o quotient < 1, result was shifted left by one
module mant_div_norm
  import divsqrt_pkg::*;
(
  input  logic [QB-1:0]   q_i,
  input  logic [NF+1:0]   rem_i,
  output logic [NF+1:0]   q_m_o,
  output logic            sticky_o,
  output logic            decrement_o
);

  always_comb begin
    q_m_o       = '0;
    sticky_o    = 1'b0;
    decrement_o = 1'b0;
    if (q_i[QB-1]) begin
      // X/D in [1,2): drop the integer bit, LSB becomes part of sticky.
      q_m_o    = q_i[QB-2:1];
      sticky_o = q_i[0] | (|rem_i);
    end else begin
      // X/D in (0.5,1): the spare bit absorbs the 1-bit left shift.
      q_m_o       = q_i[QB-3:0];
      sticky_o    = |rem_i;
      decrement_o = 1'b1;
    end
  end

endmodule

// File: rtl/mant_div.sv
// Iterative radix-2 restoring divider for normal FP significands (1.x_m / 1.d_m).
// Produces the normalized quotient fraction with G/R, a sticky bit and the exponent
// decrement flag. Optional build macro MANT_DIV_EARLY_TERM_EN finishes as soon as the
// partial remainder reaches zero (variable latency, identical results).
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   start       request, accepted only while ready=1
//   x_m, d_m    dividend / divisor fractions (sampled at acceptance)
//   ready       idle, start accepted this cycle
//   done        one-cycle pulse, results valid
//   q_m         {frac[NF-1:0], G, R}, held until the next result or reset
//   sticky      sticky bit for the downstream rounder
//   decrement   quotient < 1, feeds exponent_op.decrement
module mant_div
  import divsqrt_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [NF-1:0] x_m,
  input  logic [NF-1:0] d_m,
  output logic          ready,
  output logic          done,
  output logic [NF+1:0] q_m,
  output logic          sticky,
  output logic          decrement
);

  div_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [NF+1:0]     rem_q, rem_d;
  logic [NF:0]       div_q, div_d;
  logic [QB-1:0]     q_q, q_d;
  logic [NF+2:0]     diff;
  logic              out_en;

  logic [NF+1:0]     q_m_q, norm_q_m;
  logic              sticky_q, norm_sticky;
  logic              decrement_q, norm_decrement;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    div_d   = div_q;
    q_d     = q_q;
    out_en  = 1'b0;
    // One extra bit so the sign of rem - div is visible.
    diff    = {1'b0, rem_q} - {2'b00, div_q};

    unique case (state_q)
      StIdle: begin
        if (start) begin
          rem_d   = {2'b01, x_m};
          div_d   = {1'b1, d_m};
          q_d     = '0;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // rem < 2*div always holds, so the shifted value never loses a set bit.
        if (!diff[NF+2]) begin
          rem_d = diff[NF+1:0] << 1;
          q_d   = {q_q[QB-2:0], 1'b1};
        end else begin
          rem_d = rem_q << 1;
          q_d   = {q_q[QB-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(QB - 1)) begin
          state_d = StDone;
          out_en  = 1'b1;
        end
`ifdef MANT_DIV_EARLY_TERM_EN
        else if (rem_d == '0) begin
          // All remaining quotient bits are zero: append them in one step.
          q_d     = q_d << (CntW'(QB) - cnt_d);
          cnt_d   = CntW'(QB);
          state_d = StDone;
          out_en  = 1'b1;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Normalize the final quotient/remainder as they are written, so outputs are
  // registered on entry to DONE.
  mant_div_norm u_norm (
    .q_i         (q_d),
    .rem_i       (rem_d),
    .q_m_o       (norm_q_m),
    .sticky_o    (norm_sticky),
    .decrement_o (norm_decrement)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      q_q         <= '0;
      q_m_q       <= '0;
      sticky_q    <= 1'b0;
      decrement_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      q_q     <= q_d;
      if (out_en) begin
        q_m_q       <= norm_q_m;
        sticky_q    <= norm_sticky;
        decrement_q <= norm_decrement;
      end
    end
  end

  assign ready     = (state_q == StIdle);
  assign done      = (state_q == StDone);
  assign q_m       = q_m_q;
  assign sticky    = sticky_q;
  assign decrement = decrement_q;

endmodule

// File: tb/tb_mant_div.sv
// Self-checking bench for mant_div: table of directed divisions with hand-computed
// quotients, plus sequences for mid-operation reset, ignored start and back-to-back ops.
module tb_mant_div;

  logic        clk;
  logic        reset;
  logic        start;
  logic [22:0] x_m;
  logic [22:0] d_m;
  logic        ready;
  logic        done;
  logic [24:0] q_m;
  logic        sticky;
  logic        decrement;

  int n_checks = 0;
  int n_err    = 0;

  mant_div dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x_m       (x_m),
    .d_m       (d_m),
    .ready     (ready),
    .done      (done),
    .q_m       (q_m),
    .sticky    (sticky),
    .decrement (decrement)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [22:0] x;
    logic [22:0] d;
    logic [24:0] q_m;
    logic        sticky;
    logic        dec;
    int          lat_full;
    int          lat_et;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Drive start for exactly the accepting edge; returns #1 after that edge.
  task automatic start_op(input logic [22:0] x, input logic [22:0] d);
    x_m   = x;
    d_m   = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // lat counts cycles with the accepting edge as cycle 1.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  function automatic int exp_lat(input vec_t v);
`ifdef MANT_DIV_EARLY_TERM_EN
    return v.lat_et;
`else
    return v.lat_full;
`endif
  endfunction

  initial begin
    int lat;

    vecs[0] = '{23'h000000, 23'h000000, 25'h0000000, 1'b0, 1'b0, 28, 2};  // 1.0/1.0
    vecs[1] = '{23'h000000, 23'h400000, 25'h0AAAAAA, 1'b1, 1'b1, 28, 28}; // 1.0/1.5
    vecs[2] = '{23'h400000, 23'h000000, 25'h1000000, 1'b0, 1'b0, 28, 3};  // 1.5/1.0
    vecs[3] = '{23'h7FFFFF, 23'h000000, 25'h1FFFFFC, 1'b0, 1'b0, 28, 25}; // ~2.0/1.0
    vecs[4] = '{23'h200000, 23'h200000, 25'h0000000, 1'b0, 1'b0, 28, 2};  // 1.25/1.25
    vecs[5] = '{23'h000000, 23'h200000, 25'h1333333, 1'b1, 1'b1, 28, 28}; // 1.0/1.25

    reset = 1'b1;
    start = 1'b0;
    x_m   = '0;
    d_m   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 32'(ready), 32'd1);
    check("reset done", 32'(done), 32'd0);
    check("reset q_m", 32'(q_m), 32'd0);
    check("reset sticky", 32'(sticky), 32'd0);
    check("reset decrement", 32'(decrement), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      wait_ready();
      start_op(vecs[i].x, vecs[i].d);
      wait_done(1, lat);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(exp_lat(vecs[i])));
      check($sformatf("v%0d q_m", i), 32'(q_m), 32'(vecs[i].q_m));
      check($sformatf("v%0d sticky", i), 32'(sticky), 32'(vecs[i].sticky));
      check($sformatf("v%0d decrement", i), 32'(decrement), 32'(vecs[i].dec));
      @(posedge clk);
      #1;
      check($sformatf("v%0d held q_m", i), 32'(q_m), 32'(vecs[i].q_m));
    end

    // Reset mid-BUSY: outputs (nonzero from the last vector) clear at once.
    wait_ready();
    start_op(23'h000000, 23'h400000);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midreset ready", 32'(ready), 32'd1);
    check("midreset done", 32'(done), 32'd0);
    check("midreset q_m", 32'(q_m), 32'd0);
    check("midreset sticky", 32'(sticky), 32'd0);
    check("midreset decrement", 32'(decrement), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    start_op(vecs[3].x, vecs[3].d);
    wait_done(1, lat);
    check("postreset latency", 32'(lat), 32'(exp_lat(vecs[3])));
    check("postreset q_m", 32'(q_m), 32'(vecs[3].q_m));

    // Start pulses and operand changes during BUSY are ignored.
    @(posedge clk);
    #1;
    wait_ready();
    start_op(vecs[1].x, vecs[1].d);
    x_m   = 23'h400000;
    d_m   = 23'h000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x_m   = 23'h7FFFFF;
    wait_done(4, lat);
    check("ignore latency", 32'(lat), 32'(exp_lat(vecs[1])));
    check("ignore q_m", 32'(q_m), 32'(vecs[1].q_m));
    check("ignore sticky", 32'(sticky), 32'(vecs[1].sticky));
    check("ignore decrement", 32'(decrement), 32'(vecs[1].dec));

    // Back-to-back: start in the cycle right after DONE is accepted.
    @(posedge clk);
    #1;
    check("b2b ready", 32'(ready), 32'd1);
    check("b2b done low", 32'(done), 32'd0);
    start_op(vecs[2].x, vecs[2].d);
    check("b2b accepted", 32'(ready), 32'd0);
    wait_done(1, lat);
    check("b2b latency", 32'(lat), 32'(exp_lat(vecs[2])));
    check("b2b q_m", 32'(q_m), 32'(vecs[2].q_m));
    check("b2b decrement", 32'(decrement), 32'(vecs[2].dec));
    @(posedge clk);
    #1;
    check("done pulse width", 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
